// File: rtl/vx_pending_tags.sv
// Tag allocator for outstanding requests: grants the lowest free tag, keeps
// per-tag metadata, and hands it back when the response retires the tag.
module vx_pending_tags #(
  parameter int SIZE  = 8,
  parameter int DATAW = 32,
  parameter int ADDRW = (SIZE > 1) ? $clog2(SIZE) : 1,
  parameter int SIZEW = $clog2(SIZE + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             acquire_valid,
  input  logic [DATAW-1:0] acquire_data,
  output logic             acquire_ready,
  output logic [ADDRW-1:0] acquire_tag,
  input  logic             release_valid,
  input  logic [ADDRW-1:0] release_tag,
  output logic [DATAW-1:0] release_data,
  output logic             empty,
  output logic             full,
  output logic [SIZEW-1:0] size
);

  logic [SIZE-1:0]  busy_q, busy_d;
  logic [SIZEW-1:0] size_q, size_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic [DATAW-1:0] mem_q [SIZE];

  logic             fire;
  logic             release_in_range;
  logic             release_hit;
  logic [ADDRW-1:0] release_idx;
  logic             free_found;

  // Grant depends only on registered occupancy, so a tag freed this cycle
  // is not offered until the next one.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    acquire_tag = '0;
    free_found  = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      if (!free_found && !busy_q[i]) begin
        acquire_tag = ADDRW'(i);
        free_found  = 1'b1;
      end
    end
  end

  assign acquire_ready    = !full_q;
  assign fire             = acquire_valid && acquire_ready;
  assign release_in_range = (32'(release_tag) < 32'(SIZE));
  assign release_idx      = release_in_range ? release_tag : '0;
  // Releases of free or out-of-range tags leave the state untouched.
  assign release_hit      = release_valid && release_in_range && busy_q[release_idx];
  assign release_data     = mem_q[release_idx];

  always_comb begin
    busy_d  = busy_q;
    size_d  = size_q;
    empty_d = empty_q;
    full_d  = full_q;
    if (fire) begin
      busy_d[acquire_tag] = 1'b1;
    end
    if (release_hit) begin
      busy_d[release_idx] = 1'b0;
    end
    if (fire && !release_hit) begin
      size_d  = size_q + SIZEW'(1);
      empty_d = 1'b0;
      if (size_q == SIZEW'(SIZE - 1)) begin
        full_d = 1'b1;
      end
    end else if (release_hit && !fire) begin
      size_d = size_q - SIZEW'(1);
      full_d = 1'b0;
      if (size_q == SIZEW'(1)) begin
        empty_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= '0;
      size_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      size_q  <= size_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  // NOTE: the metadata array is deliberately not reset; a free tag's contents are never consumed.
  always_ff @(posedge clk) begin
    if (fire) begin
      mem_q[acquire_tag] <= acquire_data;
    end
  end

  assign empty = empty_q;
  assign full  = full_q;
  assign size  = size_q;

  acquire_when_full_a : assert property (@(posedge clk) disable iff (reset)
    acquire_valid |-> !full_q)
    else $error("runtime error: acquire while full");

  release_range_a : assert property (@(posedge clk) disable iff (reset)
    release_valid |-> release_in_range)
    else $error("runtime error: release tag out of range");

  release_busy_a : assert property (@(posedge clk) disable iff (reset)
    release_valid |-> busy_q[release_idx])
    else $error("runtime error: release of a free tag");

endmodule

// File: tb/tb_vx_pending_tags.sv
// Bench for vx_pending_tags: directed vectors feed a scoreboard of expected
// grants and release data, plus occupancy checks and a SIZE=1 instance.
module tb_vx_pending_tags;

  logic        clk = 1'b0;
  logic        reset;
  logic        acquire_valid;
  logic [31:0] acquire_data;
  logic        acquire_ready;
  logic [2:0]  acquire_tag;
  logic        release_valid;
  logic [2:0]  release_tag;
  logic [31:0] release_data;
  logic        empty;
  logic        full;
  logic [3:0]  size;

  logic        s1_acq_valid;
  logic [31:0] s1_acq_data;
  logic        s1_ready;
  logic [0:0]  s1_tag;
  logic        s1_rel_valid;
  logic [0:0]  s1_rel_tag;
  logic [31:0] s1_rel_data;
  logic        s1_empty;
  logic        s1_full;
  logic [0:0]  s1_size;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_tag_q  [$];
  logic [31:0] exp_data_q [$];

  always #5 clk = ~clk;

  vx_pending_tags #(.SIZE(8), .DATAW(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .acquire_valid(acquire_valid),
    .acquire_data (acquire_data),
    .acquire_ready(acquire_ready),
    .acquire_tag  (acquire_tag),
    .release_valid(release_valid),
    .release_tag  (release_tag),
    .release_data (release_data),
    .empty        (empty),
    .full         (full),
    .size         (size)
  );

  vx_pending_tags #(.SIZE(1), .DATAW(32)) dut_s1 (
    .clk          (clk),
    .reset        (reset),
    .acquire_valid(s1_acq_valid),
    .acquire_data (s1_acq_data),
    .acquire_ready(s1_ready),
    .acquire_tag  (s1_tag),
    .release_valid(s1_rel_valid),
    .release_tag  (s1_rel_tag),
    .release_data (s1_rel_data),
    .empty        (s1_empty),
    .full         (s1_full),
    .size         (s1_size)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pops one expectation for every grant and every release the DUT presents.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (acquire_valid && acquire_ready) begin
          check("acquire_tag", 32'(acquire_tag),
                (exp_tag_q.size() != 0) ? exp_tag_q.pop_front() : 32'hDEAD_BEEF);
        end
        if (release_valid) begin
          check("release_data", release_data,
                (exp_data_q.size() != 0) ? exp_data_q.pop_front() : 32'hDEAD_BEEF);
        end
      end
    end
  endtask

  task automatic drive(input logic av, input logic [31:0] ad, input logic [31:0] etag,
                       input logic rv, input logic [2:0] rt, input logic [31:0] edata);
    @(posedge clk);
    #1;
    acquire_valid = av;
    acquire_data  = ad;
    release_valid = rv;
    release_tag   = rt;
    if (av) exp_tag_q.push_back(etag);
    if (rv) exp_data_q.push_back(edata);
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 3'd0, 32'h0);
  endtask

  task automatic acq(input logic [31:0] ad, input logic [31:0] etag);
    drive(1'b1, ad, etag, 1'b0, 3'd0, 32'h0);
  endtask

  task automatic rel(input logic [2:0] rt, input logic [31:0] edata);
    drive(1'b0, 32'h0, 32'h0, 1'b1, rt, edata);
  endtask

  task automatic status(input string tag_name, input int e_size, input logic e_empty,
                        input logic e_full, input int e_tag);
    check({tag_name, ".size"},  32'(size),          32'(e_size));
    check({tag_name, ".empty"}, 32'(empty),         32'(e_empty));
    check({tag_name, ".full"},  32'(full),          32'(e_full));
    check({tag_name, ".ready"}, 32'(acquire_ready), 32'(!e_full));
    check({tag_name, ".tag"},   32'(acquire_tag),   32'(e_tag));
  endtask

  initial begin
    reset         = 1'b1;
    acquire_valid = 1'b0;
    acquire_data  = '0;
    release_valid = 1'b0;
    release_tag   = '0;
    s1_acq_valid  = 1'b0;
    s1_acq_data   = '0;
    s1_rel_valid  = 1'b0;
    s1_rel_tag    = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    status("reset", 0, 1'b1, 1'b0, 0);

    // Fill all eight tags back to back.
    for (int i = 0; i < 8; i++) acq(32'hA0 + 32'(i), 32'(i));
    idle();
    status("filled", 8, 1'b0, 1'b1, 0);

    rel(3'd3, 32'hA3);
    idle();
    status("rel3", 7, 1'b0, 1'b0, 3);

    // Trim down to tags 0-3 busy.
    for (int t = 4; t < 8; t++) rel(3'(t), 32'hA0 + 32'(t));
    idle();
    status("trim", 3, 1'b0, 1'b0, 3);
    acq(32'hC3, 32'd3);
    idle();
    status("busy0to3", 4, 1'b0, 1'b0, 4);

    // Simultaneous grant and release: size holds, freed tag offered next cycle.
    drive(1'b1, 32'hB4, 32'd4, 1'b1, 3'd1, 32'hA1);
    idle();
    status("fire_rel", 4, 1'b0, 1'b0, 1);

    acq(32'hB1, 32'd1);
    acq(32'hB5, 32'd5);
    idle();
    status("busy0to5", 6, 1'b0, 1'b0, 6);
    rel(3'd5, 32'hB5);
    rel(3'd2, 32'hA2);
    idle();
    status("rel5_2", 4, 1'b0, 1'b0, 2);
    acq(32'hD0, 32'd2);
    acq(32'hD1, 32'd5);
    idle();
    status("regrant", 6, 1'b0, 1'b0, 6);

    rel(3'd0, 32'hA0);
    rel(3'd1, 32'hB1);
    rel(3'd2, 32'hD0);
    rel(3'd3, 32'hC3);
    rel(3'd4, 32'hB4);
    idle();
    status("one_left", 1, 1'b0, 1'b0, 0);
    rel(3'd5, 32'hD1);
    idle();
    status("drained", 0, 1'b1, 1'b0, 0);

    // Reset mid-operation with a release pending.
    for (int i = 0; i < 5; i++) acq(32'hE0 + 32'(i), 32'(i));
    idle();
    status("size5", 5, 1'b0, 1'b0, 5);
    @(posedge clk);
    #1;
    reset         = 1'b1;
    release_valid = 1'b1;
    release_tag   = 3'd2;
    @(posedge clk);
    #1;
    reset         = 1'b0;
    release_valid = 1'b0;
    status("midreset", 0, 1'b1, 1'b0, 0);
    acq(32'hF0, 32'd0);
    rel(3'd0, 32'hF0);
    idle();
    status("post_reset", 0, 1'b1, 1'b0, 0);

    // Single-tag build.
    check("s1.empty0", 32'(s1_empty), 32'd1);
    check("s1.full0",  32'(s1_full),  32'd0);
    check("s1.tag0",   32'(s1_tag),   32'd0);
    s1_acq_valid = 1'b1;
    s1_acq_data  = 32'h55;
    @(posedge clk);
    #1;
    s1_acq_valid = 1'b0;
    check("s1.full1",  32'(s1_full),  32'd1);
    check("s1.empty1", 32'(s1_empty), 32'd0);
    check("s1.size1",  32'(s1_size),  32'd1);
    check("s1.ready1", 32'(s1_ready), 32'd0);
    s1_rel_valid = 1'b1;
    s1_rel_tag   = 1'b0;
    #1;
    check("s1.rel_data", s1_rel_data, 32'h55);
    @(posedge clk);
    #1;
    s1_rel_valid = 1'b0;
    check("s1.empty2", 32'(s1_empty), 32'd1);
    check("s1.full2",  32'(s1_full),  32'd0);
    check("s1.size2",  32'(s1_size),  32'd0);

    repeat (2) @(posedge clk);
    check("tag_queue_drained",  32'(exp_tag_q.size()),  32'd0);
    check("data_queue_drained", 32'(exp_data_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
